// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Byte stream handshake between the UART receiver FIFO and its consumer.
//
// Signals:
//   rx_data   8  byte at the FIFO head (producer -> consumer)
//   rx_valid  1  FIFO holds at least one byte (producer -> consumer)
//   rx_ready  1  consumer takes rx_data when rx_valid && rx_ready
//
// Modports:
//   master  the receiver side (drives rx_data/rx_valid)
//   slave   the consumer side (drives rx_ready)
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver with a small byte FIFO and sticky line-error flags.
// The serial line is synchronised, oversampled 16x and deserialised LSB
// first; good frames are pushed into a circular buffer drained through a
// valid/ready interface.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   rxd          asynchronous serial input, idle high
//   bus          uart_rx_fifo_if.master: rx_data / rx_valid / rx_ready
//   fifo_count   number of bytes currently held
//   frame_err    sticky, stop bit sampled low
//   overrun_err  sticky, byte dropped because the FIFO was full
//   err_clear    one-cycle pulse clearing both sticky flags
//
// Optional build macro: UART_RX_MAJORITY_EN
//   When defined, every bit is the majority of the samples at ticks 7, 8
//   and 9 and the decision is made at tick 9. Otherwise a single sample is
//   taken at tick 8.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int TICK_DIV   = 54,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rxd,
    uart_rx_fifo_if.master                  bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            frame_err,
    output logic                            overrun_err,
    input  logic                            err_clear
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t      state, next_state;
    logic        sync1, rxs;
    logic [15:0] presc;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        tick, wrap, mid, bit_val;
    logic        push, frame_set, shift_en, idx_inc;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, push_ok, overrun_set;

    // Two-flop synchroniser; both stages reset to the idle (high) level so
    // reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    assign tick = (presc == 16'(TICK_DIV - 1));
    assign wrap = tick && (tick_cnt == 4'(OVERSAMPLE - 1));

`ifdef UART_RX_MAJORITY_EN
    logic samp7, samp8;

    // Keep the tick-7 and tick-8 samples; the vote closes at tick 9 with
    // the live sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp7 <= 1'b1;
            samp8 <= 1'b1;
        end else if (presc == 16'd0) begin
            if (tick_cnt == 4'd7) samp7 <= rxs;
            if (tick_cnt == 4'd8) samp8 <= rxs;
        end
    end

    assign mid     = (presc == 16'd0) && (tick_cnt == 4'd9);
    assign bit_val = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);
`else
    assign mid     = (presc == 16'd0) && (tick_cnt == 4'd8);
    assign bit_val = rxs;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state and frame control. Bit boundaries fall on the 15->0 tick
    // wrap so each bit's sample point sits mid-bit relative to the start edge.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        frame_set  = 1'b0;
        shift_en   = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs) next_state = ST_START;
            end
            ST_START: begin
                if (mid && bit_val) next_state = ST_IDLE;
                else if (wrap)      next_state = ST_DATA;
            end
            ST_DATA: begin
                if (mid) shift_en = 1'b1;
                if (wrap) begin
                    if (bit_idx == 3'd7) next_state = ST_STOP;
                    else                 idx_inc    = 1'b1;
                end
            end
            ST_STOP: begin
                if (mid) begin
                    if (bit_val) begin
                        push       = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        next_state = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Prescaler, tick counter, bit index and shift register. The counters
    // are held at zero whenever the receiver is or is about to be idle, so
    // the next start edge always begins counting from a clean zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= 16'd0;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            if (state == ST_IDLE || next_state == ST_IDLE) begin
                presc    <= 16'd0;
                tick_cnt <= 4'd0;
            end else if (tick) begin
                presc    <= 16'd0;
                tick_cnt <= tick_cnt + 4'd1;
            end else begin
                presc    <= presc + 16'd1;
            end

            if (state != ST_DATA) bit_idx <= 3'd0;
            else if (idx_inc)     bit_idx <= bit_idx + 3'd1;

            if (shift_en) shift <= {bit_val, shift[7:1]};
        end
    end

    assign full        = (fifo_count == CW'(FIFO_DEPTH));
    assign pop         = bus.rx_valid && bus.rx_ready;
    assign push_ok     = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    // FIFO storage; contents need no reset because rx_valid gates the head.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift;
    end

    // FIFO pointers and occupancy. Pointers are AW bits wide so they wrap
    // modulo the power-of-two depth on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.rx_valid = (fifo_count != '0);
    assign bus.rx_data  = bus.rx_valid ? mem[rd_ptr] : 8'h00;

    // Sticky error flags; a new error event takes priority over err_clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (frame_set)      frame_err <= 1'b1;
            else if (err_clear) frame_err <= 1'b0;

            if (overrun_set)    overrun_err <= 1'b1;
            else if (err_clear) overrun_err <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synthesizable UART receiver for the Microwatt user project. It consumes the serial line driven onto mprj_io[5] (uart_rx) and deserializes 8N1 frames. It buffers received bytes in a small FIFO that the Microwatt UART register block drains through a valid/ready interface. Line errors are reported as sticky flags.

Parameters:
TICK_DIV, 54, clk cycles per oversample tick (100 MHz / (115200*16) ≈ 54); legal range 2..65535
OVERSAMPLE, 16, ticks per bit period; fixed at 16 (the sample points below depend on it)
FIFO_DEPTH, 16, number of byte entries; must be a power of 2, range 2..64

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rxd  input  1  asynchronous serial input; idle level is high
rx_data  output  8  byte at the FIFO head
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
fifo_count  output  $clog2(FIFO_DEPTH+1)  number of bytes currently held
frame_err  output  1  sticky; stop bit was sampled low
overrun_err  output  1  sticky; a byte was dropped because the FIFO was full
err_clear  input  1  one-cycle pulse that clears both sticky flags

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: rx_valid=0, fifo_count=0, frame_err=0, overrun_err=0, rx_data=0. FSM goes to IDLE. Both synchronizer flops are set to 1. Prescaler and bit counters clear. A reset mid-frame discards the partial byte.
- Synchronizer: rxd passes through 2 flops to give rxs. All logic uses rxs only.
- Tick generator: counts 0..TICK_DIV-1 and emits a one-cycle tick on the wrap. It is held at 0 in IDLE and restarts on start detection, so sampling aligns to the falling edge.
- tick_cnt: 4 bits, advanced on each tick, range 0..15 within a bit.
- FSM states:
  - IDLE: rxs==0 -> START, with tick_cnt=0.
  - START: at tick_cnt==8, evaluate the sample. If it is 1, treat it as a glitch and return to IDLE with no error. If it is 0, go to DATA with bit_idx=0 and tick_cnt=0 on the following tick.
  - DATA: at tick_cnt==8, shift the sample into shift[7] and shift right (LSB first). After bit_idx 7, go to STOP.
  - STOP: at tick_cnt==8, evaluate the sample. If it is 1, push shift into the FIFO and go to IDLE. If it is 0, set frame_err, discard the byte and go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. A held-low line therefore produces exactly one frame_err and no bytes.
- Push latency: the byte becomes visible (rx_valid and fifo_count update) on the clk edge after the stop-bit sample cycle.
- FIFO:
  - Circular buffer; the read and write pointers wrap modulo FIFO_DEPTH.
  - rx_data shows the head combinationally from registers and is stable while rx_valid && !rx_ready.
  - Pop when rx_valid && rx_ready.
  - Push while full: the byte is dropped and overrun_err is set.
  - Push and pop in the same cycle while full: both succeed, the count is unchanged and no overrun.
  - Push and pop in the same cycle while empty: the push succeeds, there is no pop, and the count goes to 1.
- Sticky flags: err_clear clears both flags. If an error event and err_clear occur in the same cycle, the event wins and the flag stays 1.
- The frame has no parity and one stop bit. A start edge occurring during BREAK is ignored.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value (start, data, stop) is the majority of the samples taken at tick_cnt 7, 8 and 9. The decision is made at tick_cnt==9 and all state transitions move from tick 8 to tick 9. Push latency grows by one tick.
- Undefined: a single sample is taken at tick_cnt==8, as specified above.

Test Plan:
- Idle-high reset check: assert rst for 2 cycles with rxd=1. Then rx_valid=0, fifo_count=0, and both error flags are 0 for 100 µs.
- Single byte: send 0x37 ('7') at 8680 ns/bit with rx_ready=0. Then rx_valid=1 and rx_data=0x37 within 1 tick of the stop-bit midpoint, fifo_count=1. Pulse rx_ready -> fifo_count=0.
- Glitch rejection: drive rxd low for 2 µs, then high. No byte is received, FSM returns to IDLE, frame_err=0.
- Framing error: send 0x55 with the stop bit low, then hold rxd low for 200 µs before releasing. frame_err=1, fifo_count=0, then a following 0xA3 is received correctly. An err_clear pulse then gives frame_err=0.
- Overrun: with FIFO_DEPTH=16 and rx_ready=0, send 17 bytes 0x00..0x10. fifo_count=16, overrun_err=1, and the drained sequence is 0x00..0x0F.
- Full with simultaneous pop: with the FIFO full, assert rx_ready exactly on the push cycle of byte 0x5A. overrun_err stays 0, fifo_count stays 16, and 0x5A is the last byte drained.
